// File: rtl/vga_timing_rx.sv
// Purpose: VGA timing receiver; measures line/frame lengths, tracks pixel coordinates, detects stable lock.
// Latency: pixel outputs and pulses are registered, one pclk after the sampled inputs.
// Backpressure: none; the video stream is free-running and cannot be stalled.
//
// Ports: pclk/reset (async, active-high); hsync/vsync (active-low sync), de, rgb in;
//        pix_valid/pix_data/pix_x/pix_y out; line_start/frame_start pulses;
//        h_total/v_total last measured line/frame length; locked; err pulse.
module vga_timing_rx #(
    parameter int H_MIN = 16
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    input  logic [23:0] rgb,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        line_start,
    output logic        frame_start,
    output logic [10:0] h_total,
    output logic [10:0] v_total,
    output logic        locked,
    output logic        err
);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, CHECK, LOCKED} state_t;

    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam logic [11:0] H_MIN_W   = 12'(H_MIN);

    state_t      state;
    logic        hs_d, vs_d, de_d;
    logic [10:0] hcnt, vcnt;
    logic [9:0]  xcnt, ycnt;
    logic [10:0] ref_h, ref_v;

    logic        hfall_raw, hfall, vfall, defall;
    logic        glitch, timeout;
    logic [11:0] h_len;
    logic [10:0] hcnt_p1, vcnt_p1;

    always_comb begin
        hfall_raw = hs_d & ~hsync;
        vfall     = vs_d & ~vsync;
        defall    = de_d & ~de;
        h_len     = {1'b0, hcnt} + 12'd1;
        hcnt_p1   = hcnt + 11'd1;
        vcnt_p1   = vcnt + 11'd1;
        // While qualifying a candidate timing, a too-short line is treated as
        // sync noise: it neither restarts the line nor counts as a new line.
        glitch    = (state == CHECK) && hfall_raw && (h_len < H_MIN_W);
        hfall     = hfall_raw & ~glitch;
        timeout   = (hcnt == CNT_MAX) || (vcnt == CNT_MAX);
    end

    // Measurement and pixel datapath
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            de_d        <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            xcnt        <= '0;
            ycnt        <= '0;
            h_total     <= '0;
            v_total     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
        end else begin
            hs_d <= hsync;
            vs_d <= vsync;
            de_d <= de;

            if (hfall)                 hcnt <= '0;
            else if (hcnt != CNT_MAX)  hcnt <= hcnt_p1;

            // A line start coincident with frame start is line 0, not an extra line.
            if (vfall)                          vcnt <= '0;
            else if (hfall && vcnt != CNT_MAX)  vcnt <= vcnt_p1;

            if (hfall)    xcnt <= '0;
            else if (de)  xcnt <= xcnt + 10'd1;

            if (vfall)        ycnt <= '0;
            else if (defall)  ycnt <= ycnt + 10'd1;

            if (hfall) h_total <= hcnt_p1;
            if (vfall) v_total <= vcnt_p1;

            line_start  <= hfall;
            frame_start <= vfall;

            pix_valid <= de;
            pix_data  <= rgb;
            pix_x     <= xcnt;
            pix_y     <= ycnt;
        end
    end

    // Lock tracking: one frame to start, one to capture a reference, one to confirm.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state  <= UNLOCKED;
            ref_h  <= '0;
            ref_v  <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                UNLOCKED: begin
                    if (vfall) state <= ACQUIRE;
                end
                ACQUIRE: begin
                    if (timeout) begin
                        err   <= 1'b1;
                        state <= UNLOCKED;
                    end else if (vfall) begin
                        ref_h <= h_total;
                        ref_v <= vcnt_p1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (timeout) begin
                        err   <= 1'b1;
                        state <= UNLOCKED;
                    end else if (vfall) begin
                        if (vcnt_p1 == ref_v && h_total == ref_h) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            ref_h <= h_total;
                            ref_v <= vcnt_p1;
                        end
                    end
                end
                LOCKED: begin
                    if (timeout || (hfall && hcnt_p1 != ref_h) ||
                        (vfall && vcnt_p1 != ref_v)) begin
                        err    <= 1'b1;
                        locked <= 1'b0;
                        state  <= UNLOCKED;
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
module tb_vga_timing_rx;

    localparam int HMIN = 8;

    logic        pclk = 1'b0;
    logic        reset;
    logic        hsync, vsync, de;
    logic [23:0] rgb;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic [9:0]  pix_x, pix_y;
    logic        line_start, frame_start;
    logic [10:0] h_total, v_total;
    logic        locked, err;

    vga_timing_rx #(.H_MIN(HMIN)) dut (
        .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start),
        .h_total(h_total), .v_total(v_total), .locked(locked), .err(err)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;

    // Outputs sampled at the start of each tick (reflect the previous tick's inputs)
    logic        s_valid, s_ls, s_fs, s_locked, s_err;
    logic [23:0] s_data;
    logic [9:0]  s_x, s_y;
    logic [10:0] s_ht, s_vt;

    typedef struct {
        int hs, vs, de, rgb;
        int valid, data, x, y, ls, fs, ht, vt;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".pix_valid"},   int'(pix_valid), 0);
        chk({tag, ".pix_data"},    int'(pix_data), 0);
        chk({tag, ".pix_x"},       int'(pix_x), 0);
        chk({tag, ".pix_y"},       int'(pix_y), 0);
        chk({tag, ".line_start"},  int'(line_start), 0);
        chk({tag, ".frame_start"}, int'(frame_start), 0);
        chk({tag, ".h_total"},     int'(h_total), 0);
        chk({tag, ".v_total"},     int'(v_total), 0);
        chk({tag, ".locked"},      int'(locked), 0);
        chk({tag, ".err"},         int'(err), 0);
    endtask

    task automatic tick(input logic h, input logic v, input logic d, input logic [23:0] c);
        @(negedge pclk);
        s_valid  = pix_valid;  s_data = pix_data;  s_x = pix_x;  s_y = pix_y;
        s_ls     = line_start; s_fs   = frame_start;
        s_ht     = h_total;    s_vt   = v_total;
        s_locked = locked;     s_err  = err;
        if (err === 1'b1) err_cnt++;
        hsync = h; vsync = v; de = d; rgb = c;
    endtask

    task automatic pulse_reset();
        @(negedge pclk);
        reset = 1'b1; hsync = 1'b1; vsync = 1'b1; de = 1'b0; rgb = '0;
        repeat (2) @(negedge pclk);
        reset = 1'b0;
        repeat (3) tick(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    // Called right after a tick (at a falling clock edge): 3-cycle reset mid-frame
    task automatic mid_reset();
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        repeat (3) @(negedge pclk);
        reset = 1'b0;
    endtask

    // One frame of 525 lines, sync falls aligned with line 0. Lines 523/524 (and the
    // first nlong lines) are full 800-cycle lines; other lines are compressed to 10
    // cycles so several frames fit in a short run.
    task automatic run_frame(input int nlong, input int nlines, input int short_ln,
                             input int rst_ln, input int glitch_ln, input bit pix,
                             input int exp_lock, input int exp_vtot);
        for (int ln = 0; ln < nlines; ln++) begin
            logic lng, act;
            int   len;
            lng = (ln < nlong) || (ln >= 523) || (pix && ln == 514);
            act = (ln >= 35) && (ln <= 514);
            len = lng ? ((ln == short_ln) ? 799 : 800) : 10;
            for (int c = 0; c < len; c++) begin
                logic h, d;
                if (lng) begin
                    h = !(c < 96);
                    d = act && c >= 144 && c < 784;
                end else begin
                    h = !(c < 2 || (ln == glitch_ln && c == 5));
                    d = act && c >= 4 && c < 8;
                end
                tick(h, !(ln < 2), d, {8'(ln), 16'(c)});

                if (ln == 0 && c == 0 && exp_lock >= 0) chk("locked_before_vfall", int'(s_locked), 0);
                if (ln == 0 && c == 1) begin
                    chk("frame_start", int'(s_fs), 1);
                    chk("line_start_with_frame", int'(s_ls), 1);
                    if (exp_lock >= 0) chk("locked_after_vfall", int'(s_locked), exp_lock);
                    if (exp_vtot >= 0) begin
                        chk("v_total", int'(s_vt), exp_vtot);
                        chk("h_total", int'(s_ht), 800);
                    end
                end
                if (short_ln >= 0) begin
                    if (ln == short_ln && c == 5) chk("locked_before_short", int'(s_locked), 1);
                    if (ln == short_ln + 1 && c == 1) begin
                        chk("short_err", int'(s_err), 1);
                        chk("short_unlock", int'(s_locked), 0);
                    end
                    if (ln == short_ln + 1 && c == 2) chk("short_err_once", int'(s_err), 0);
                end
                if (ln == glitch_ln && c == 6) chk("glitch_no_line_start", int'(s_ls), 0);
                if (pix) begin
                    if (ln == 35 && c == 4) chk("first_px_valid_lag", int'(s_valid), 0);
                    if (ln == 35 && c == 5) begin
                        chk("first_px_valid", int'(s_valid), 1);
                        chk("first_px_x", int'(s_x), 0);
                        chk("first_px_y", int'(s_y), 0);
                        chk("first_px_data", int'(s_data), 24'h230004);
                    end
                    if (ln == 514 && c == 784) begin
                        chk("last_px_valid", int'(s_valid), 1);
                        chk("last_px_x", int'(s_x), 639);
                        chk("last_px_y", int'(s_y), 479);
                        chk("last_px_data", int'(s_data), 24'h02030F);
                    end
                    if (ln == 514 && c == 785) chk("after_last_px_valid", int'(s_valid), 0);
                end
                if (ln == rst_ln && c == 5) mid_reset();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int e0;
        reset = 1'b1; hsync = 1'b1; vsync = 1'b1; de = 1'b0; rgb = '0;

        //            hs vs de rgb        | valid data      x  y ls fs ht vt
        tbl[0] = '{1, 1, 0, 'h111111, 0, 'h111111, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 'h222222, 0, 'h222222, 0, 0, 1, 1, 2, 1};
        tbl[2] = '{0, 0, 1, 'hABCDEF, 1, 'hABCDEF, 0, 0, 0, 0, 2, 1};
        tbl[3] = '{1, 1, 1, 'h123456, 1, 'h123456, 1, 0, 0, 0, 2, 1};
        tbl[4] = '{1, 1, 0, 'h654321, 0, 'h654321, 2, 0, 0, 0, 2, 1};
        tbl[5] = '{1, 1, 0, 'h000000, 0, 'h000000, 2, 1, 0, 0, 2, 1};
        tbl[6] = '{0, 1, 1, 'h0F0F0F, 1, 'h0F0F0F, 2, 1, 1, 0, 5, 1};
        tbl[7] = '{0, 1, 1, 'hF0F0F0, 1, 'hF0F0F0, 0, 1, 0, 0, 5, 1};
        tbl[8] = '{1, 0, 0, 'h777777, 0, 'h777777, 1, 1, 0, 1, 5, 2};
        tbl[9] = '{1, 1, 0, 'h000001, 0, 'h000001, 1, 0, 0, 0, 5, 2};

        repeat (2) @(negedge pclk);
        chk_zero("reset_state");

        // Cycle-accurate vectors; reset is released together with the first vector
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            reset = 1'b0;
            hsync = tbl[i].hs[0]; vsync = tbl[i].vs[0]; de = tbl[i].de[0];
            rgb   = 24'(tbl[i].rgb);
            @(posedge pclk);
            #1;
            chk($sformatf("vec%0d.pix_valid", i),   int'(pix_valid),   tbl[i].valid);
            chk($sformatf("vec%0d.pix_data", i),    int'(pix_data),    tbl[i].data);
            chk($sformatf("vec%0d.pix_x", i),       int'(pix_x),       tbl[i].x);
            chk($sformatf("vec%0d.pix_y", i),       int'(pix_y),       tbl[i].y);
            chk($sformatf("vec%0d.line_start", i),  int'(line_start),  tbl[i].ls);
            chk($sformatf("vec%0d.frame_start", i), int'(frame_start), tbl[i].fs);
            chk($sformatf("vec%0d.h_total", i),     int'(h_total),     tbl[i].ht);
            chk($sformatf("vec%0d.v_total", i),     int'(v_total),     tbl[i].vt);
            chk($sformatf("vec%0d.locked", i),      int'(locked),      0);
        end

        // Lock acquisition, pixel window, then a 799-cycle line while locked
        pulse_reset();
        run_frame(0, 525, -1, -1, -1, 1'b0, 0, -1);
        run_frame(0, 525, -1, -1, -1, 1'b1, 0, 525);
        run_frame(2, 525,  1, -1, -1, 1'b0, 1, 525);
        chk("err_count_after_short_line", err_cnt, 1);

        // Re-lock after three more frames; frame 5 carries a short hsync glitch
        run_frame(0, 525, -1, -1,  -1, 1'b0, 0, 525);
        run_frame(0, 525, -1, -1, 100, 1'b0, 0, 525);
        run_frame(1,   1, -1, -1,  -1, 1'b0, 1, 525);

        // hsync stuck high while locked: timeout when hcnt saturates
        e0 = err_cnt;
        for (int h = 0; h < 2100; h++) begin
            tick(1'b1, 1'b1, 1'b0, 24'h0);
            if (h == 0)    chk("hold_locked_start", int'(s_locked), 1);
            if (h == 1248) chk("hold_err_early", int'(s_err), 0);
            if (h == 1249) begin
                chk("hold_timeout_err", int'(s_err), 1);
                chk("hold_unlocked", int'(s_locked), 0);
            end
        end
        chk("hold_err_pulses", err_cnt - e0, 1);
        chk("hold_h_total", int'(s_ht), 800);
        chk("hold_still_unlocked", int'(s_locked), 0);

        // Reset at line 200 while qualifying; lock must restart from scratch
        pulse_reset();
        run_frame(0, 525, -1,  -1, -1, 1'b0, 0, -1);
        run_frame(0, 525, -1, 200, -1, 1'b0, 0, 525);
        run_frame(0, 525, -1,  -1, -1, 1'b0, 0, 325);
        run_frame(0, 525, -1,  -1, -1, 1'b0, 0, 525);
        run_frame(1,   1, -1,  -1, -1, 1'b0, 1, 525);
        chk("total_err_pulses", err_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL have parameter H_MIN, default 16: minimum line length, in pclk cycles, accepted as a valid line.
REQ-002 SHALL have port pclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports hsync and vsync, input, 1 bit each: active-low sync pulses; a sync pulse starts on the falling edge.
REQ-005 SHALL have port de, input, 1 bit: data-enable (active video).
REQ-006 SHALL have port rgb, input, 24 bits: pixel data {r,g,b}.
REQ-007 SHALL have port pix_valid, output, 1 bit: registered copy of de.
REQ-008 SHALL have port pix_data, output, 24 bits: registered copy of rgb.
REQ-009 SHALL have ports pix_x and pix_y, output, 10 bits each: active-pixel coordinates.
REQ-010 SHALL have ports line_start and frame_start, output, 1 bit each: one-cycle pulses.
REQ-011 SHALL have ports h_total and v_total, output, 11 bits each: last measured line length (pclk cycles) and frame length (lines).
REQ-012 SHALL have port locked, output, 1 bit: stable timing detected.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse on loss of lock or timeout.

Function
REQ-014 SHALL hold previous-cycle copies hs_d, vs_d, de_d; hfall = hs_d & ~hsync; vfall = vs_d & ~vsync; defall = de_d & ~de.
REQ-015 SHALL keep an 11-bit hcnt: set to 0 on hfall, otherwise increment, saturating at 2047.
REQ-016 SHALL, on hfall, load h_total <= hcnt+1 and pulse line_start in the following cycle; an 800-cycle line gives h_total = 800.
REQ-017 SHALL keep an 11-bit vcnt: set to 0 on vfall, otherwise increment on hfall, saturating at 2047.
REQ-018 SHALL, on vfall, load v_total <= vcnt+1 and pulse frame_start in the following cycle.
REQ-019 SHALL treat an hfall coincident with a vfall as line 0 of the new frame; in that case vcnt SHALL NOT also increment.
REQ-020 SHALL keep a 10-bit xcnt: set to 0 on hfall; increment on each cycle with de=1 and no hfall.
REQ-021 SHALL keep a 10-bit ycnt: set to 0 on vfall; increment on defall.
REQ-022 SHALL give vfall priority over defall when both occur in the same cycle.
REQ-023 SHALL register pix_valid <= de, pix_data <= rgb, pix_x <= xcnt and pix_y <= ycnt, all sampled in the same cycle (one-cycle latency); the coordinates are pre-increment values.
REQ-024 SHALL implement lock FSM state UNLOCKED: on vfall go to ACQUIRE.
REQ-025 SHALL implement lock FSM state ACQUIRE: on vfall store ref_h <= h_total and ref_v <= vcnt+1, then go to CHECK.
REQ-026 SHALL implement lock FSM state CHECK: on vfall, if vcnt+1 == ref_v and h_total == ref_h go to LOCKED; otherwise reload ref_h/ref_v and stay in CHECK.
REQ-027 SHALL implement lock FSM state LOCKED: on hfall with hcnt+1 != ref_h, or on vfall with vcnt+1 != ref_v, pulse err and go to UNLOCKED.
REQ-028 SHALL assert locked only in state LOCKED.
REQ-029 SHALL, in any state other than UNLOCKED, pulse err and go to UNLOCKED when hcnt or vcnt reaches 2047 (timeout).
REQ-030 SHALL, while in CHECK, ignore an hfall with hcnt+1 < H_MIN (glitch): hcnt continues counting and vcnt does not increment.

Reset
REQ-031 SHALL, while reset=1, asynchronously clear all counters, h_total, v_total, pix_* outputs, line_start, frame_start, locked and err to 0.
REQ-032 SHALL, while reset=1, set hs_d=1, vs_d=1, de_d=0 and the FSM to UNLOCKED.
REQ-033 SHALL, on reset asserted mid-frame, fully discard lock, and re-lock only after three further vfalls.

Verification
REQ-034 SHALL be verified with 800x525 timing, hsync low for 96 cycles, 640x480 de window: locked=1 one cycle after the third vfall, h_total=800, v_total=525.
REQ-035 SHALL be verified on first and last active pixels of a frame: pix_valid rises one cycle after de with pix_x=0, pix_y=0; the last pixel shows pix_x=639, pix_y=479.
REQ-036 SHALL be verified by shortening one line to 799 cycles while locked: err pulses once, locked=0 next cycle, locked=1 again after three more vfalls.
REQ-037 SHALL be verified by holding hsync high after lock: err pulses when hcnt reaches 2047, FSM returns to UNLOCKED, h_total remains 800.
REQ-038 SHALL be verified with a simultaneous hfall+vfall: v_total=525 (not 526), line_start and frame_start pulse in the same cycle.
REQ-039 SHALL be verified by asserting reset at line 200 for 3 cycles: all outputs are 0 immediately; after release, locked=1 only after the third vfall.
